// File: rtl/grid_video_pkg.sv
// Shared video timing and colour constants for grid/overlay renderers.
// Also holds the per-pixel pipeline bundle and colour select helper.
package grid_video_pkg;

    localparam int DEF_GRID_ROWS = 30;
    localparam int DEF_GRID_COLS = 40;
    localparam int DEF_CELL_SIZE = 8;

    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 16;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_FP   = 4;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 14;

    localparam logic [23:0] DEF_ON_COLOR  = 24'hFFFFFF;
    localparam logic [23:0] DEF_OFF_COLOR = 24'h000000;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic on;
    } pix_stage_t;

    function automatic logic [23:0] cell_color(
        input logic        de,
        input logic        on,
        input logic [23:0] on_c,
        input logic [23:0] off_c
    );
        if (!de)
            return 24'h000000;
        return on ? on_c : off_c;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters plus active/sync/shadow-load decode and cell row/col.
// Decode outputs are combinational from the counter registers.
module video_timing_gen
    import grid_video_pkg::*;
#(
    parameter int GRID_ROWS = DEF_GRID_ROWS,
    parameter int GRID_COLS = DEF_GRID_COLS,
    parameter int CELL_SIZE = DEF_CELL_SIZE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    localparam int SHIFT    = $clog2(CELL_SIZE),
    localparam int H_ACTIVE = GRID_COLS * CELL_SIZE,
    localparam int V_ACTIVE = GRID_ROWS * CELL_SIZE,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic                clk_74a,
    input  logic                reset_n,
    input  logic                pix_ce,
    output logic                active,
    output logic                hs,
    output logic                vs,
    output logic                load,
    output logic [HW-SHIFT-1:0] col,
    output logic [VW-SHIFT-1:0] row
);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;

    assign h_last = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign active = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign hs     = (h_cnt == HW'(H_ACTIVE + H_FP));
    assign vs     = (v_cnt == VW'(V_ACTIVE + V_FP)) && (h_cnt == '0);
    // Reload point sits on the first blanking line, well clear of any lookup.
    assign load   = (v_cnt == VW'(V_ACTIVE)) && (h_cnt == '0);
    assign col    = h_cnt[HW-1:SHIFT];
    assign row    = v_cnt[VW-1:SHIFT];

endmodule

// File: rtl/grid_video_renderer.sv
// Cell-grid scan-out: shadow grid, cell lookup and 2-stage output pipe.
// DE/HS/VS/RGB all travel through the same stages and stay aligned.
module grid_video_renderer
    import grid_video_pkg::*;
#(
    parameter int          GRID_ROWS = DEF_GRID_ROWS,
    parameter int          GRID_COLS = DEF_GRID_COLS,
    parameter int          CELL_SIZE = DEF_CELL_SIZE,
    parameter int          H_FP      = DEF_H_FP,
    parameter int          H_SYNC    = DEF_H_SYNC,
    parameter int          H_BP      = DEF_H_BP,
    parameter int          V_FP      = DEF_V_FP,
    parameter int          V_SYNC    = DEF_V_SYNC,
    parameter int          V_BP      = DEF_V_BP,
    parameter logic [23:0] ON_COLOR  = DEF_ON_COLOR,
    parameter logic [23:0] OFF_COLOR = DEF_OFF_COLOR,
    localparam int CELLS    = GRID_ROWS * GRID_COLS,
    localparam int IW       = $clog2(CELLS),
    localparam int SHIFT    = $clog2(CELL_SIZE),
    localparam int H_ACTIVE = GRID_COLS * CELL_SIZE,
    localparam int V_ACTIVE = GRID_ROWS * CELL_SIZE,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic             clk_74a,
    input  logic             reset_n,
    input  logic             pix_ce,
    input  logic [0:CELLS-1] grid_ram,
    output logic [23:0]      video_rgb,
    output logic             video_de,
    output logic             video_hs,
    output logic             video_vs,
    output logic             frame_start
);

    logic                active;
    logic                hs;
    logic                vs;
    logic                load;
    logic [HW-SHIFT-1:0] col;
    logic [VW-SHIFT-1:0] row;

    logic [0:CELLS-1]    shadow;
    logic [IW-1:0]       cell_idx;
    logic                cell_on;
    pix_stage_t          s1;

    video_timing_gen #(
        .GRID_ROWS (GRID_ROWS),
        .GRID_COLS (GRID_COLS),
        .CELL_SIZE (CELL_SIZE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP)
    ) u_timing (
        .clk_74a (clk_74a),
        .reset_n (reset_n),
        .pix_ce  (pix_ce),
        .active  (active),
        .hs      (hs),
        .vs      (vs),
        .load    (load),
        .col     (col),
        .row     (row)
    );

    // Index is forced to 0 in blanking so it never runs past the grid.
    assign cell_idx = active ? IW'(int'(row) * GRID_COLS + int'(col)) : '0;
    assign cell_on  = active & shadow[cell_idx];

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (pix_ce && load) begin
            shadow <= grid_ram;
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce & load;
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            s1        <= '0;
            video_rgb <= '0;
            video_de  <= 1'b0;
            video_hs  <= 1'b0;
            video_vs  <= 1'b0;
        end else if (pix_ce) begin
            s1        <= '{de: active, hs: hs, vs: vs, on: cell_on};
            video_rgb <= cell_color(s1.de, s1.on, ON_COLOR, OFF_COLOR);
            video_de  <= s1.de;
            video_hs  <= s1.hs;
            video_vs  <= s1.vs;
        end
    end

endmodule
